// File: rtl/core_pkg.sv
// Shared widths, reserved tag and slot state encoding used by the dispatch path.
package core_pkg;
   localparam int DEF_REG_WIDTH  = 5;
   localparam int DEF_ID_WIDTH   = 32;
   localparam int DEF_ROB_WIDTH  = 4;
   localparam int DEF_ADDR_WIDTH = 32;
   localparam int DEF_OP_WIDTH   = 6;
   localparam int DEF_NUM_CDB    = 2;

   localparam logic [DEF_OP_WIDTH-1:0]  OP_NOP    = '0;
   // Tag 0 never names a ROB entry: an operand carrying it is already a value.
   localparam logic [DEF_ROB_WIDTH-1:0] TAG_READY = '0;

   typedef enum logic {ST_EMPTY, ST_HELD} slot_state_e;
endpackage

// File: rtl/dispatch_stage_if.sv
// Decoder-side handshake and issue-side bundle (RS, ROB allocate, rename write).
interface dispatch_stage_if
   import core_pkg::*;
#(
   parameter int REG_WIDTH  = DEF_REG_WIDTH,
   parameter int ID_WIDTH   = DEF_ID_WIDTH,
   parameter int ROB_WIDTH  = DEF_ROB_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int OP_WIDTH   = DEF_OP_WIDTH
);
   logic                  dec_valid_in;
   logic                  dec_ready_out;
   logic [REG_WIDTH-1:0]  dec_rs_in;
   logic [REG_WIDTH-1:0]  dec_rt_in;
   logic [REG_WIDTH-1:0]  dec_rd_in;
   logic [ID_WIDTH-1:0]   dec_imm_in;
   logic [OP_WIDTH-1:0]   dec_op_in;
   logic [ADDR_WIDTH-1:0] dec_pc_in;
   logic                  bp_taken_in;

   logic                  rs_en_out;
   logic [ID_WIDTH-1:0]   rs_vj_out;
   logic [ID_WIDTH-1:0]   rs_vk_out;
   logic [ID_WIDTH-1:0]   rs_a_out;
   logic [ROB_WIDTH-1:0]  rs_qj_out;
   logic [ROB_WIDTH-1:0]  rs_qk_out;
   logic [ROB_WIDTH-1:0]  rs_dest_out;
   logic [OP_WIDTH-1:0]   rs_op_out;
   logic [ADDR_WIDTH-1:0] rs_pc_out;
   logic                  rob_en_out;
   logic [OP_WIDTH-1:0]   rob_op_out;
   logic [REG_WIDTH-1:0]  rob_dest_out;
   logic [ADDR_WIDTH-1:0] rob_pc_out;
   logic                  rob_taken_out;
   logic                  rf_rd_en_out;
   logic [REG_WIDTH-1:0]  rf_rd_out;
   logic [ROB_WIDTH-1:0]  rf_rd_tag_out;

   modport master (
      output dec_valid_in, dec_rs_in, dec_rt_in, dec_rd_in, dec_imm_in, dec_op_in,
             dec_pc_in, bp_taken_in,
      input  dec_ready_out, rs_en_out, rs_vj_out, rs_vk_out, rs_a_out, rs_qj_out,
             rs_qk_out, rs_dest_out, rs_op_out, rs_pc_out, rob_en_out, rob_op_out,
             rob_dest_out, rob_pc_out, rob_taken_out, rf_rd_en_out, rf_rd_out, rf_rd_tag_out
   );

   modport slave (
      input  dec_valid_in, dec_rs_in, dec_rt_in, dec_rd_in, dec_imm_in, dec_op_in,
             dec_pc_in, bp_taken_in,
      output dec_ready_out, rs_en_out, rs_vj_out, rs_vk_out, rs_a_out, rs_qj_out,
             rs_qk_out, rs_dest_out, rs_op_out, rs_pc_out, rob_en_out, rob_op_out,
             rob_dest_out, rob_pc_out, rob_taken_out, rf_rd_en_out, rf_rd_out, rf_rd_tag_out
   );
endinterface

// File: rtl/dispatch_stage_operand_resolve.sv
// One source operand: priority resolve at capture, and CDB merge of the held operand.
module operand_resolve
   import core_pkg::*;
#(
   parameter int REG_WIDTH = DEF_REG_WIDTH,
   parameter int ID_WIDTH  = DEF_ID_WIDTH,
   parameter int ROB_WIDTH = DEF_ROB_WIDTH,
   parameter int NUM_CDB   = DEF_NUM_CDB
)
(
   input  logic [REG_WIDTH-1:0]         src,
   input  logic                         hazard,
   input  logic [ROB_WIDTH-1:0]         hazard_tag,
   input  logic                         rf_busy,
   input  logic [ID_WIDTH-1:0]          rf_val,
   input  logic [ROB_WIDTH-1:0]         rf_tag,
   input  logic                         rob_ready,
   input  logic [ID_WIDTH-1:0]          rob_val,
   input  logic [NUM_CDB-1:0]           cdb_valid,
   input  logic [NUM_CDB*ROB_WIDTH-1:0] cdb_tag,
   input  logic [NUM_CDB*ID_WIDTH-1:0]  cdb_val,
   input  logic [ID_WIDTH-1:0]          held_v,
   input  logic [ROB_WIDTH-1:0]         held_q,
   output logic [ID_WIDTH-1:0]          cap_v,
   output logic [ROB_WIDTH-1:0]         cap_q,
   output logic [ID_WIDTH-1:0]          merged_v,
   output logic [ROB_WIDTH-1:0]         merged_q
);
   logic [ID_WIDTH-1:0] chan_val [NUM_CDB];
   logic [NUM_CDB-1:0]  cap_hit;
   logic [NUM_CDB-1:0]  held_hit;
   logic                cap_cdb_hit;
   logic [ID_WIDTH-1:0] cap_cdb_val;
   logic                held_cdb_hit;
   logic [ID_WIDTH-1:0] held_cdb_val;

   for (genvar gi = 0; gi < NUM_CDB; gi++) begin : g_cdb
      assign chan_val[gi] = cdb_val[gi*ID_WIDTH +: ID_WIDTH];
      assign cap_hit[gi]  = cdb_valid[gi] && (rf_tag != TAG_READY) &&
                            (cdb_tag[gi*ROB_WIDTH +: ROB_WIDTH] == rf_tag);
      assign held_hit[gi] = cdb_valid[gi] && (held_q != TAG_READY) &&
                            (cdb_tag[gi*ROB_WIDTH +: ROB_WIDTH] == held_q);
   end

   // Scan from the top so the lowest matching channel is the last writer.
   always_comb begin
      cap_cdb_hit  = 1'b0;
      cap_cdb_val  = '0;
      held_cdb_hit = 1'b0;
      held_cdb_val = '0;
      for (int i = NUM_CDB - 1; i >= 0; i--) begin
         if (cap_hit[i]) begin
            cap_cdb_hit = 1'b1;
            cap_cdb_val = chan_val[i];
         end
         if (held_hit[i]) begin
            held_cdb_hit = 1'b1;
            held_cdb_val = chan_val[i];
         end
      end
   end

   always_comb begin
      cap_v = '0;
      cap_q = '0;
      if (src == '0) begin
         cap_v = '0;
      end else if (hazard) begin
         cap_q = hazard_tag;
      end else if (!rf_busy) begin
         cap_v = rf_val;
      end else if (rob_ready) begin
         cap_v = rob_val;
      end else if (cap_cdb_hit) begin
         cap_v = cap_cdb_val;
      end else begin
         cap_q = rf_tag;
      end
   end

   assign merged_v = held_cdb_hit ? held_cdb_val : held_v;
   assign merged_q = held_cdb_hit ? '0 : held_q;
endmodule

// File: rtl/dispatch_stage.sv
// Single-slot registered dispatch: capture, resolve/snoop operands, issue to RS and ROB.
module dispatch_stage
   import core_pkg::*;
#(
   parameter int REG_WIDTH  = DEF_REG_WIDTH,
   parameter int ID_WIDTH   = DEF_ID_WIDTH,
   parameter int ROB_WIDTH  = DEF_ROB_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int OP_WIDTH   = DEF_OP_WIDTH,
   parameter int NUM_CDB    = DEF_NUM_CDB
)
(
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic                         rdy_in,
   input  logic                         flush_in,
   dispatch_stage_if.slave              dif,
   output logic [REG_WIDTH-1:0]         rf_rs_out,
   output logic [REG_WIDTH-1:0]         rf_rt_out,
   input  logic                         rf_rs_busy_in,
   input  logic                         rf_rt_busy_in,
   input  logic [ID_WIDTH-1:0]          rf_rs_val_in,
   input  logic [ID_WIDTH-1:0]          rf_rt_val_in,
   input  logic [ROB_WIDTH-1:0]         rf_rs_tag_in,
   input  logic [ROB_WIDTH-1:0]         rf_rt_tag_in,
   output logic [ROB_WIDTH-1:0]         rob_rs_h_out,
   output logic [ROB_WIDTH-1:0]         rob_rt_h_out,
   input  logic                         rob_rs_ready_in,
   input  logic                         rob_rt_ready_in,
   input  logic [ID_WIDTH-1:0]          rob_rs_val_in,
   input  logic [ID_WIDTH-1:0]          rob_rt_val_in,
   input  logic [ROB_WIDTH-1:0]         rob_tail_in,
   input  logic                         rob_free_in,
   input  logic                         rs_free_in,
   input  logic [NUM_CDB-1:0]           cdb_valid_in,
   input  logic [NUM_CDB*ROB_WIDTH-1:0] cdb_tag_in,
   input  logic [NUM_CDB*ID_WIDTH-1:0]  cdb_val_in
);
   slot_state_e           state_reg;
   logic [REG_WIDTH-1:0]  rd_reg;
   logic [OP_WIDTH-1:0]   op_reg;
   logic [ADDR_WIDTH-1:0] pc_reg;
   logic [ID_WIDTH-1:0]   imm_reg;
   logic                  taken_reg;
   logic [ROB_WIDTH-1:0]  dest_reg;
   logic [ID_WIDTH-1:0]   vj_reg, vk_reg;
   logic [ROB_WIDTH-1:0]  qj_reg, qk_reg;

   logic                  slot_valid, fire, ready, capture, haz_rs, haz_rt;
   logic [ID_WIDTH-1:0]   cap_vj, cap_vk, merged_vj, merged_vk;
   logic [ROB_WIDTH-1:0]  cap_qj, cap_qk, merged_qj, merged_qk;

   assign slot_valid = (state_reg == ST_HELD);
   assign fire       = slot_valid & rs_free_in & rob_free_in & ~flush_in & rdy_in;
   assign ready      = (~slot_valid | fire) & ~flush_in;
   assign capture    = dif.dec_valid_in & ready & rdy_in;
   // The held rename reaches the regfile only at this edge, so forward it by hand.
   assign haz_rs     = fire && (rd_reg != '0) && (dif.dec_rs_in == rd_reg);
   assign haz_rt     = fire && (rd_reg != '0) && (dif.dec_rt_in == rd_reg);

   operand_resolve #(
      .REG_WIDTH(REG_WIDTH), .ID_WIDTH(ID_WIDTH), .ROB_WIDTH(ROB_WIDTH), .NUM_CDB(NUM_CDB)
   ) u_rs (
      .src(dif.dec_rs_in), .hazard(haz_rs), .hazard_tag(dest_reg),
      .rf_busy(rf_rs_busy_in), .rf_val(rf_rs_val_in), .rf_tag(rf_rs_tag_in),
      .rob_ready(rob_rs_ready_in), .rob_val(rob_rs_val_in),
      .cdb_valid(cdb_valid_in), .cdb_tag(cdb_tag_in), .cdb_val(cdb_val_in),
      .held_v(vj_reg), .held_q(qj_reg),
      .cap_v(cap_vj), .cap_q(cap_qj), .merged_v(merged_vj), .merged_q(merged_qj)
   );

   operand_resolve #(
      .REG_WIDTH(REG_WIDTH), .ID_WIDTH(ID_WIDTH), .ROB_WIDTH(ROB_WIDTH), .NUM_CDB(NUM_CDB)
   ) u_rt (
      .src(dif.dec_rt_in), .hazard(haz_rt), .hazard_tag(dest_reg),
      .rf_busy(rf_rt_busy_in), .rf_val(rf_rt_val_in), .rf_tag(rf_rt_tag_in),
      .rob_ready(rob_rt_ready_in), .rob_val(rob_rt_val_in),
      .cdb_valid(cdb_valid_in), .cdb_tag(cdb_tag_in), .cdb_val(cdb_val_in),
      .held_v(vk_reg), .held_q(qk_reg),
      .cap_v(cap_vk), .cap_q(cap_qk), .merged_v(merged_vk), .merged_q(merged_qk)
   );

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_reg <= ST_EMPTY;
         rd_reg    <= '0;
         op_reg    <= OP_WIDTH'(OP_NOP);
         pc_reg    <= '0;
         imm_reg   <= '0;
         taken_reg <= 1'b0;
         dest_reg  <= '0;
         vj_reg    <= '0;
         vk_reg    <= '0;
         qj_reg    <= '0;
         qk_reg    <= '0;
      end else if (flush_in) begin
         state_reg <= ST_EMPTY;
      end else if (rdy_in) begin
         case (state_reg)
            ST_EMPTY: if (capture) state_reg <= ST_HELD;
            ST_HELD:  if (fire && !capture) state_reg <= ST_EMPTY;
            default:  state_reg <= ST_EMPTY;
         endcase
         if (capture) begin
            rd_reg    <= dif.dec_rd_in;
            op_reg    <= dif.dec_op_in;
            pc_reg    <= dif.dec_pc_in;
            imm_reg   <= dif.dec_imm_in;
            taken_reg <= dif.bp_taken_in;
            dest_reg  <= rob_tail_in;
            vj_reg    <= cap_vj;
            vk_reg    <= cap_vk;
            qj_reg    <= cap_qj;
            qk_reg    <= cap_qk;
         end else if (slot_valid) begin
            vj_reg <= merged_vj;
            vk_reg <= merged_vk;
            qj_reg <= merged_qj;
            qk_reg <= merged_qk;
         end
      end
   end

   assign dif.dec_ready_out = ready;
   assign rf_rs_out         = dif.dec_rs_in;
   assign rf_rt_out         = dif.dec_rt_in;
   assign rob_rs_h_out      = rf_rs_tag_in;
   assign rob_rt_h_out      = rf_rt_tag_in;

   assign dif.rs_en_out     = fire;
   assign dif.rs_vj_out     = merged_vj;
   assign dif.rs_vk_out     = merged_vk;
   assign dif.rs_qj_out     = merged_qj;
   assign dif.rs_qk_out     = merged_qk;
   assign dif.rs_a_out      = imm_reg;
   assign dif.rs_dest_out   = dest_reg;
   assign dif.rs_op_out     = op_reg;
   assign dif.rs_pc_out     = pc_reg;
   assign dif.rob_en_out    = fire;
   assign dif.rob_op_out    = op_reg;
   assign dif.rob_dest_out  = rd_reg;
   assign dif.rob_pc_out    = pc_reg;
   assign dif.rob_taken_out = taken_reg;
   assign dif.rf_rd_en_out  = fire & (rd_reg != '0);
   assign dif.rf_rd_out     = rd_reg;
   assign dif.rf_rd_tag_out = dest_reg;
endmodule

// File: tb/tb_dispatch_stage.sv
// Directed test-plan cases plus randomized traffic against a one-slot queue model.
module tb_dispatch_stage;
   import core_pkg::*;

   localparam int RW = DEF_REG_WIDTH;
   localparam int IW = DEF_ID_WIDTH;
   localparam int TW = DEF_ROB_WIDTH;
   localparam int AW = DEF_ADDR_WIDTH;
   localparam int OW = DEF_OP_WIDTH;
   localparam int NC = DEF_NUM_CDB;

   typedef struct packed {
      logic [RW-1:0] rd;
      logic [OW-1:0] op;
      logic [AW-1:0] pc;
      logic [IW-1:0] imm;
      logic          taken;
      logic [TW-1:0] dest;
      logic [IW-1:0] vj;
      logic [TW-1:0] qj;
      logic [IW-1:0] vk;
      logic [TW-1:0] qk;
   } inst_t;

   logic clk = 1'b0;
   logic rst_n, rdy, flush;
   logic [RW-1:0] rf_rs_a, rf_rt_a;
   logic rf_rs_busy, rf_rt_busy;
   logic [IW-1:0] rf_rs_val, rf_rt_val;
   logic [TW-1:0] rf_rs_tag, rf_rt_tag;
   logic [TW-1:0] rob_rs_h, rob_rt_h;
   logic rob_rs_ready, rob_rt_ready;
   logic [IW-1:0] rob_rs_val, rob_rt_val;
   logic [TW-1:0] rob_tail;
   logic rob_free, rs_free;
   logic [NC-1:0] cdb_valid;
   logic [NC*TW-1:0] cdb_tag;
   logic [NC*IW-1:0] cdb_val;

   int n_cmp = 0;
   int n_bad = 0;
   inst_t slot_q[$];

   dispatch_stage_if dif ();

   dispatch_stage dut (
      .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .flush_in(flush), .dif(dif),
      .rf_rs_out(rf_rs_a), .rf_rt_out(rf_rt_a),
      .rf_rs_busy_in(rf_rs_busy), .rf_rt_busy_in(rf_rt_busy),
      .rf_rs_val_in(rf_rs_val), .rf_rt_val_in(rf_rt_val),
      .rf_rs_tag_in(rf_rs_tag), .rf_rt_tag_in(rf_rt_tag),
      .rob_rs_h_out(rob_rs_h), .rob_rt_h_out(rob_rt_h),
      .rob_rs_ready_in(rob_rs_ready), .rob_rt_ready_in(rob_rt_ready),
      .rob_rs_val_in(rob_rs_val), .rob_rt_val_in(rob_rt_val),
      .rob_tail_in(rob_tail), .rob_free_in(rob_free), .rs_free_in(rs_free),
      .cdb_valid_in(cdb_valid), .cdb_tag_in(cdb_tag), .cdb_val_in(cdb_val)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // First (lowest) valid channel broadcasting a nonzero tag supplies the value.
   function automatic logic cdb_lookup(input logic [TW-1:0] tag, output logic [IW-1:0] val);
      val = '0;
      if (tag == 0) return 1'b0;
      for (int i = 0; i < NC; i++) begin
         if (cdb_valid[i] && cdb_tag[i*TW +: TW] == tag) begin
            val = cdb_val[i*IW +: IW];
            return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   task automatic resolve(input logic [RW-1:0] src, input logic haz, input logic [TW-1:0] htag,
                          input logic busy, input logic [IW-1:0] rfv, input logic [TW-1:0] rft,
                          input logic rrdy, input logic [IW-1:0] rv,
                          output logic [IW-1:0] v, output logic [TW-1:0] q);
      logic [IW-1:0] cv;
      logic hit;
      hit = cdb_lookup(rft, cv);
      v = '0;
      q = '0;
      if (src == 0) ;
      else if (haz) q = htag;
      else if (!busy) v = rfv;
      else if (rrdy) v = rv;
      else if (hit) v = cv;
      else q = rft;
   endtask

   // Called with inputs already driven for this cycle; checks outputs, then advances the model.
   task automatic model_check();
      logic fire_e, ready_e, hit;
      logic [IW-1:0] hv, vj_e, vk_e;
      logic [TW-1:0] qj_e, qk_e;
      inst_t cur, nxt;
      #1;
      if (!rst_n) slot_q.delete();
      cur = (slot_q.size() != 0) ? slot_q[0] : '0;
      fire_e  = rst_n && (slot_q.size() != 0) && rs_free && rob_free && !flush && rdy;
      ready_e = ((slot_q.size() == 0) || fire_e) && !flush;
      chk("rs_en", dif.rs_en_out, fire_e);
      chk("rob_en", dif.rob_en_out, fire_e);
      chk("rf_rd_en", dif.rf_rd_en_out, fire_e && cur.rd != 0);
      chk("dec_ready", dif.dec_ready_out, ready_e);
      chk("rf_rs_addr", rf_rs_a, dif.dec_rs_in);
      chk("rf_rt_addr", rf_rt_a, dif.dec_rt_in);
      chk("rob_rs_h", rob_rs_h, rf_rs_tag);
      chk("rob_rt_h", rob_rt_h, rf_rt_tag);
      vj_e = cur.vj; qj_e = cur.qj;
      vk_e = cur.vk; qk_e = cur.qk;
      hit = cdb_lookup(cur.qj, hv);
      if (hit) begin vj_e = hv; qj_e = 0; end
      hit = cdb_lookup(cur.qk, hv);
      if (hit) begin vk_e = hv; qk_e = 0; end
      if (slot_q.size() != 0) begin
         chk("vj", dif.rs_vj_out, vj_e);
         chk("qj", dif.rs_qj_out, qj_e);
         chk("vk", dif.rs_vk_out, vk_e);
         chk("qk", dif.rs_qk_out, qk_e);
         chk("a", dif.rs_a_out, cur.imm);
         chk("dest", dif.rs_dest_out, cur.dest);
         chk("rs_op", dif.rs_op_out, cur.op);
         chk("rs_pc", dif.rs_pc_out, cur.pc);
         chk("rob_op", dif.rob_op_out, cur.op);
         chk("rob_dest", dif.rob_dest_out, cur.rd);
         chk("rob_pc", dif.rob_pc_out, cur.pc);
         chk("rob_taken", dif.rob_taken_out, cur.taken);
         chk("rf_rd", dif.rf_rd_out, cur.rd);
         chk("rf_rd_tag", dif.rf_rd_tag_out, cur.dest);
      end
      if (!rst_n) ;
      else if (flush) slot_q.delete();
      else if (rdy) begin
         if (fire_e) void'(slot_q.pop_front());
         else if (slot_q.size() != 0) begin
            slot_q[0].vj = vj_e; slot_q[0].qj = qj_e;
            slot_q[0].vk = vk_e; slot_q[0].qk = qk_e;
         end
         if (dif.dec_valid_in && ready_e) begin
            nxt.rd = dif.dec_rd_in;   nxt.op = dif.dec_op_in;
            nxt.pc = dif.dec_pc_in;   nxt.imm = dif.dec_imm_in;
            nxt.taken = dif.bp_taken_in;
            nxt.dest = rob_tail;
            resolve(dif.dec_rs_in, fire_e && cur.rd != 0 && dif.dec_rs_in == cur.rd, cur.dest,
                    rf_rs_busy, rf_rs_val, rf_rs_tag, rob_rs_ready, rob_rs_val, nxt.vj, nxt.qj);
            resolve(dif.dec_rt_in, fire_e && cur.rd != 0 && dif.dec_rt_in == cur.rd, cur.dest,
                    rf_rt_busy, rf_rt_val, rf_rt_tag, rob_rt_ready, rob_rt_val, nxt.vk, nxt.qk);
            slot_q.push_back(nxt);
         end
      end
   endtask

   task automatic idle();
      rdy = 1; flush = 0; rs_free = 1; rob_free = 1;
      dif.dec_valid_in = 0; dif.dec_rs_in = 0; dif.dec_rt_in = 0; dif.dec_rd_in = 0;
      dif.dec_imm_in = 0; dif.dec_op_in = 0; dif.dec_pc_in = 0; dif.bp_taken_in = 0;
      rf_rs_busy = 0; rf_rt_busy = 0; rf_rs_val = 0; rf_rt_val = 0; rf_rs_tag = 0; rf_rt_tag = 0;
      rob_rs_ready = 0; rob_rt_ready = 0; rob_rs_val = 0; rob_rt_val = 0;
      rob_tail = 0; cdb_valid = 0; cdb_tag = 0; cdb_val = 0;
   endtask

   task automatic present(input logic [RW-1:0] rs, input logic [RW-1:0] rt, input logic [RW-1:0] rd,
                          input logic [TW-1:0] tail);
      dif.dec_valid_in = 1; dif.dec_rs_in = rs; dif.dec_rt_in = rt; dif.dec_rd_in = rd;
      rob_tail = tail;
   endtask

   task automatic next_cycle();
      @(negedge clk);
      idle();
   endtask

   initial begin
      rst_n = 0;
      idle();
      flush = 0;
      repeat (3) @(negedge clk);
      cdb_valid = 2'b11; cdb_tag = 8'h00; cdb_val = {32'h1234, 32'h5678};
      model_check();
      chk("reset rs_en", dif.rs_en_out, 0);
      chk("reset rf_rd_en", dif.rf_rd_en_out, 0);
      chk("reset dec_ready", dif.dec_ready_out, 1);
      chk("reset vj", dif.rs_vj_out, 0);
      chk("reset qk", dif.rs_qk_out, 0);
      chk("reset dest", dif.rs_dest_out, 0);
      chk("reset op", dif.rs_op_out, 0);
      chk("reset pc", dif.rob_pc_out, 0);
      next_cycle();
      rst_n = 1;

      // Ready operands
      present(1, 2, 3, 5);
      rf_rs_val = 32'h10; rf_rt_val = 32'h20;
      dif.dec_op_in = 6'h0a; dif.dec_pc_in = 32'h100; dif.dec_imm_in = 32'h44; dif.bp_taken_in = 1;
      model_check();
      next_cycle();
      model_check();
      chk("t1 rs_en", dif.rs_en_out, 1);
      chk("t1 rob_en", dif.rob_en_out, 1);
      chk("t1 rf_rd_en", dif.rf_rd_en_out, 1);
      chk("t1 vj", dif.rs_vj_out, 32'h10);
      chk("t1 vk", dif.rs_vk_out, 32'h20);
      chk("t1 qj", dif.rs_qj_out, 0);
      chk("t1 dest", dif.rs_dest_out, 5);
      chk("t1 rf_rd", dif.rf_rd_out, 3);
      chk("t1 op", dif.rs_op_out, 6'h0a);
      chk("t1 a", dif.rs_a_out, 32'h44);
      next_cycle();

      // Pending in ROB, woken by cdb[1] while stalled
      present(1, 0, 7, 8);
      rf_rs_busy = 1; rf_rs_tag = 3;
      model_check();
      next_cycle(); rs_free = 0;
      model_check();
      chk("t2 qj held", dif.rs_qj_out, 3);
      chk("t2 stalled", dif.rs_en_out, 0);
      chk("t2 dec_ready", dif.dec_ready_out, 0);
      next_cycle(); rs_free = 0;
      cdb_valid = 2'b10; cdb_tag = {4'd3, 4'd0}; cdb_val = {32'h99, 32'h0};
      model_check();
      next_cycle();
      model_check();
      chk("t2 release en", dif.rs_en_out, 1);
      chk("t2 release vj", dif.rs_vj_out, 32'h99);
      chk("t2 release qj", dif.rs_qj_out, 0);
      next_cycle();

      // Back-to-back dependency through the rename hazard
      present(0, 0, 4, 6);
      model_check();
      next_cycle();
      present(4, 0, 9, 7);
      rf_rs_val = 32'h5555;
      model_check();
      chk("t3 A fire", dif.rs_en_out, 1);
      chk("t3 A tag", dif.rf_rd_tag_out, 6);
      chk("t3 B accept", dif.dec_ready_out, 1);
      next_cycle();
      model_check();
      chk("t3 B en", dif.rs_en_out, 1);
      chk("t3 B qj", dif.rs_qj_out, 6);
      chk("t3 B dest", dif.rs_dest_out, 7);
      next_cycle();

      // Same-cycle CDB bypass at issue
      present(0, 2, 1, 9);
      rf_rt_busy = 1; rf_rt_tag = 2;
      model_check();
      next_cycle();
      cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd2}; cdb_val = {32'h0, 32'hAB};
      model_check();
      chk("t4 en", dif.rs_en_out, 1);
      chk("t4 qk", dif.rs_qk_out, 0);
      chk("t4 vk", dif.rs_vk_out, 32'hAB);
      next_cycle();

      // Backpressure then flush
      present(1, 2, 3, 10);
      model_check();
      for (int i = 0; i < 2; i++) begin
         next_cycle(); rob_free = 0;
         model_check();
         chk("t5 bp ready", dif.dec_ready_out, 0);
         chk("t5 bp en", dif.rs_en_out, 0);
      end
      next_cycle(); flush = 1;
      model_check();
      chk("t5 flush en", dif.rs_en_out, 0);
      chk("t5 flush rf_rd_en", dif.rf_rd_en_out, 0);
      chk("t5 flush ready", dif.dec_ready_out, 0);
      next_cycle();
      model_check();
      chk("t5 after ready", dif.dec_ready_out, 1);
      chk("t5 after en", dif.rs_en_out, 0);
      next_cycle();

      // Register x0 and reset mid-HELD
      present(0, 0, 0, 11);
      rf_rs_busy = 1; rf_rs_tag = 5; rf_rs_val = 32'h77;
      model_check();
      next_cycle();
      model_check();
      chk("t6 en", dif.rs_en_out, 1);
      chk("t6 vj", dif.rs_vj_out, 0);
      chk("t6 qj", dif.rs_qj_out, 0);
      chk("t6 rf_rd_en", dif.rf_rd_en_out, 0);
      next_cycle();
      present(1, 2, 5, 12);
      model_check();
      next_cycle(); rob_free = 0;
      model_check();
      next_cycle(); rst_n = 0;
      model_check();
      chk("t6 rst en", dif.rs_en_out, 0);
      chk("t6 rst rf_rd_en", dif.rf_rd_en_out, 0);
      next_cycle(); rst_n = 1;
      model_check();
      chk("t6 dropped en", dif.rs_en_out, 0);
      chk("t6 dropped ready", dif.dec_ready_out, 1);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         next_cycle();
         rst_n = ($urandom_range(0, 299) != 0);
         rdy = ($urandom_range(0, 9) != 0);
         flush = ($urandom_range(0, 24) == 0);
         rs_free = ($urandom_range(0, 3) != 0);
         rob_free = ($urandom_range(0, 4) != 0);
         dif.dec_valid_in = ($urandom_range(0, 2) != 0);
         dif.dec_rs_in = RW'($urandom_range(0, 7));
         dif.dec_rt_in = RW'($urandom_range(0, 7));
         dif.dec_rd_in = RW'($urandom_range(0, 7));
         dif.dec_imm_in = $urandom; dif.dec_pc_in = $urandom;
         dif.dec_op_in = OW'($urandom_range(0, 63));
         dif.bp_taken_in = 1'($urandom_range(0, 1));
         rf_rs_busy = 1'($urandom_range(0, 1)); rf_rt_busy = 1'($urandom_range(0, 1));
         rf_rs_val = $urandom; rf_rt_val = $urandom;
         rf_rs_tag = TW'($urandom_range(1, 6)); rf_rt_tag = TW'($urandom_range(1, 6));
         rob_rs_ready = ($urandom_range(0, 3) == 0); rob_rt_ready = ($urandom_range(0, 3) == 0);
         rob_rs_val = $urandom; rob_rt_val = $urandom;
         rob_tail = TW'($urandom_range(1, 15));
         for (int k = 0; k < NC; k++) begin
            cdb_valid[k] = ($urandom_range(0, 2) == 0);
            cdb_tag[k*TW +: TW] = TW'($urandom_range(0, 7));
            cdb_val[k*IW +: IW] = $urandom;
         end
         model_check();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
